// File: rtl/ajuste_color_ctrl.sv
// ajuste_color_ctrl
// Front-panel controller for the VGA colour datapath. The Up/Down/TC/Lp
// buttons are synchronised, debounced and decoded into commands that either
// rotate the selected channel or step the selected channel's level in a
// shadow copy of the 3-3-2 colour. The shadow is copied into the visible
// registers by a small commit FSM.
//
// Configuration macro: FRAME_SYNC_COMMIT_EN
//   defined   : commits wait for a falling edge of Vsinc (tear-free update)
//   undefined : Vsinc is ignored; visible follows shadow one clock later
//
// Ports
//   Clock    in   system clock
//   reset    in   asynchronous, active-low reset
//   Up       in   raw button, step +
//   Down     in   raw button, step -
//   TC       in   raw button, held = channel-select mode (wins over Lp)
//   Lp       in   raw button, held = level mode
//   Vsinc    in   vertical sync, active-low, synchronous to Clock
//   Rojo     out  visible red level   (0..7)
//   Verde    out  visible green level (0..7)
//   Azul     out  visible blue level  (0..3)
//   sel      out  selected channel 0=R 1=G 2=B
//   pending  out  shadow awaiting commit
module ajuste_color_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [7:0] RESET_RGB       = 8'hFF
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       Up,
    input  logic       Down,
    input  logic       TC,
    input  logic       Lp,
    input  logic       Vsinc,
    output logic [2:0] Rojo,
    output logic [2:0] Verde,
    output logic [1:0] Azul,
    output logic [1:0] sel,
    output logic       pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    // Button vector order: {Lp, TC, Down, Up}
    logic [3:0]    rawBtn;
    logic [3:0]    sync1_q, sync2_q, db_q;
    logic [1:0]    edgePrev_q;
    logic [CW-1:0] cnt_q [4];

    logic upPulse, downPulse, tcLvl, lpLvl;

    logic [1:0] sel_q, sel_d;
    logic [2:0] rojo_q, rojo_d, verde_q, verde_d;
    logic [1:0] azul_q, azul_d;
    logic [2:0] visRojo_q, visVerde_q;
    logic [1:0] visAzul_q;

    state_t state_q, state_d;
    logic   pending_q;
    logic   shadowChange;
    logic   frameEdge;

    assign rawBtn = {Lp, TC, Down, Up};

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawBtn;
            sync2_q <= sync1_q;
        end
    end

    // The debounced level only flips after the synced level has disagreed
    // with it for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts
    // the count.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            db_q       <= '0;
            edgePrev_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            edgePrev_q <= db_q[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[i]  <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign upPulse   = db_q[0] & ~edgePrev_q[0];
    assign downPulse = db_q[1] & ~edgePrev_q[1];
    assign tcLvl     = db_q[2];
    assign lpLvl     = db_q[3];

    // Command decode: channel rotation wraps modulo 3, level steps saturate.
    // Simultaneous Up and Down pulses cancel out.
    always_comb begin
        sel_d   = sel_q;
        rojo_d  = rojo_q;
        verde_d = verde_q;
        azul_d  = azul_q;
        if (upPulse ^ downPulse) begin
            if (tcLvl) begin
                if (upPulse) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                else         sel_d = (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
            end else if (lpLvl) begin
                case (sel_q)
                    2'd0: begin
                        if (upPulse && rojo_q != 3'd7)        rojo_d = rojo_q + 3'd1;
                        else if (downPulse && rojo_q != 3'd0) rojo_d = rojo_q - 3'd1;
                    end
                    2'd1: begin
                        if (upPulse && verde_q != 3'd7)        verde_d = verde_q + 3'd1;
                        else if (downPulse && verde_q != 3'd0) verde_d = verde_q - 3'd1;
                    end
                    2'd2: begin
                        if (upPulse && azul_q != 2'd3)        azul_d = azul_q + 2'd1;
                        else if (downPulse && azul_q != 2'd0) azul_d = azul_q - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign shadowChange = {rojo_d, verde_d, azul_d} != {rojo_q, verde_q, azul_q};

`ifdef FRAME_SYNC_COMMIT_EN
    localparam state_t PENDING_ENTRY = WAIT_FRAME;
    logic vsPrev_q;

    // Vsinc is already synchronous; one register is enough to spot its fall
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) vsPrev_q <= 1'b0;
        else        vsPrev_q <= Vsinc;
    end

    assign frameEdge = vsPrev_q & ~Vsinc;
`else
    // Without frame alignment a change heads straight for the commit cycle
    localparam state_t PENDING_ENTRY = COMMIT;
    logic unusedVsinc;

    assign unusedVsinc = Vsinc;
    assign frameEdge   = 1'b1;
`endif

    // Commit FSM next state. A change landing in the COMMIT cycle is newer
    // than what is being copied, so it must go round again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (shadowChange) state_d = PENDING_ENTRY;
            WAIT_FRAME: if (frameEdge)    state_d = COMMIT;
            COMMIT:     state_d = shadowChange ? PENDING_ENTRY : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Shadow, visible and FSM registers
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sel_q      <= 2'd0;
            rojo_q     <= RESET_RGB[7:5];
            verde_q    <= RESET_RGB[4:2];
            azul_q     <= RESET_RGB[1:0];
            visRojo_q  <= RESET_RGB[7:5];
            visVerde_q <= RESET_RGB[4:2];
            visAzul_q  <= RESET_RGB[1:0];
            state_q    <= IDLE;
            pending_q  <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            rojo_q    <= rojo_d;
            verde_q   <= verde_d;
            azul_q    <= azul_d;
            state_q   <= state_d;
            pending_q <= (state_d != IDLE);
            if (state_q == COMMIT) begin
                visRojo_q  <= rojo_q;
                visVerde_q <= verde_q;
                visAzul_q  <= azul_q;
            end
        end
    end

    assign Rojo    = visRojo_q;
    assign Verde   = visVerde_q;
    assign Azul    = visAzul_q;
    assign sel     = sel_q;
    assign pending = pending_q;

endmodule
